// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_pkg
//  Description : Shared constants for the shared-ALU arbiter: ALU command
//                codes and the arbiter FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

    // ALU command codes carried on req_cmd
    localparam logic [2:0] c_CMD_ADD  = 3'd0;
    localparam logic [2:0] c_CMD_SUB  = 3'd1;
    localparam logic [2:0] c_CMD_XOR  = 3'd2;
    localparam logic [2:0] c_CMD_SLT  = 3'd3;
    localparam logic [2:0] c_CMD_AND  = 3'd4;
    localparam logic [2:0] c_CMD_NAND = 3'd5;
    localparam logic [2:0] c_CMD_NOR  = 3'd6;
    localparam logic [2:0] c_CMD_OR   = 3'd7;

    // Arbiter FSM state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans requests starting at
//                i_ptr and wrapping modulo NUM_REQ; returns the first set
//                request as a one-hot grant plus its index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_idx,
    output logic               o_any
);

    localparam logic [IDW:0] c_NUM_REQ_W = (IDW+1)'(NUM_REQ);

    // Candidate index for each scan position: (i_ptr + k) mod NUM_REQ
    logic [IDW-1:0] w_cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [IDW:0] w_sum;
        logic [IDW:0] w_wrap;
        assign w_sum     = {1'b0, i_ptr} + (IDW+1)'(k);
        assign w_wrap    = (w_sum >= c_NUM_REQ_W) ? (w_sum - c_NUM_REQ_W) : w_sum;
        assign w_cand[k] = w_wrap[IDW-1:0];
    end

    // First requester found in scan order wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[w_cand[k]]) begin
                o_any              = 1'b1;
                o_grant[w_cand[k]] = 1'b1;
                o_grant_idx        = w_cand[k];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one 32-bit 8-op ALU between NUM_REQ requesters.
//                Round-robin grant, operand/command latch, one op in flight,
//                response register held until accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_cmd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_carryout,
    output logic                  resp_zero,
    output logic                  resp_overflow
);

    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     w_rr_ptr_nxt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_grant_any;
    logic               w_accept;
    logic               w_release;

    logic [31:0]        w_a_arr   [NUM_REQ];
    logic [31:0]        w_b_arr   [NUM_REQ];
    logic [2:0]         w_cmd_arr [NUM_REQ];

    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [2:0]         r_op_cmd;
    logic [IDW-1:0]     r_op_id;

    logic               w_is_sub;
    logic [31:0]        w_b_eff;
    logic [32:0]        w_sum;
    logic               w_add_ovf;
    logic [31:0]        w_alu_result;
    logic               w_alu_carry;
    logic               w_alu_ovf;

    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic [31:0]        r_resp_result;
    logic               r_resp_carry;
    logic               r_resp_zero;
    logic               r_resp_ovf;

    // Unpack per-requester operand buses for indexed selection
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_a_arr[i]   = req_a[32*i +: 32];
        assign w_b_arr[i]   = req_b[32*i +: 32];
        assign w_cmd_arr[i] = req_cmd[3*i +: 3];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_grant_any)
    );

    // Next-state logic: accept only in IDLE, release on response handshake
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (resp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Ready pulses only for the granted requester while idle and out of reset
    assign req_ready    = (w_accept && !reset) ? w_grant : '0;
    assign w_rr_ptr_nxt = (w_grant_idx == c_LAST_ID) ? '0 : (w_grant_idx + IDW'(1));

    // FSM state and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_rr_ptr_nxt;
            end
        end
    end

    // Operand/command latch captured on the accept handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_cmd <= c_CMD_ADD;
            r_op_id  <= '0;
        end else if (w_accept) begin
            r_op_a   <= w_a_arr[w_grant_idx];
            r_op_b   <= w_b_arr[w_grant_idx];
            r_op_cmd <= w_cmd_arr[w_grant_idx];
            r_op_id  <= w_grant_idx;
        end
    end

    // ALU: SUB and SLT share the adder with inverted B and carry-in of 1.
    // Carryout/overflow come from the adder for ADD/SUB/SLT, zero for logic ops.
    always_comb begin
        w_is_sub  = (r_op_cmd == c_CMD_SUB) || (r_op_cmd == c_CMD_SLT);
        w_b_eff   = w_is_sub ? ~r_op_b : r_op_b;
        w_sum     = {1'b0, r_op_a} + {1'b0, w_b_eff} + {32'd0, w_is_sub};
        w_add_ovf = (r_op_a[31] == w_b_eff[31]) && (w_sum[31] != r_op_a[31]);
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        case (r_op_cmd)
            c_CMD_ADD, c_CMD_SUB: begin
                w_alu_result = w_sum[31:0];
                w_alu_carry  = w_sum[32];
                w_alu_ovf    = w_add_ovf;
            end
            c_CMD_SLT: begin
                w_alu_result = {31'd0, w_sum[31] ^ w_add_ovf};
                w_alu_carry  = w_sum[32];
                w_alu_ovf    = w_add_ovf;
            end
            c_CMD_XOR:  w_alu_result = r_op_a ^ r_op_b;
            c_CMD_AND:  w_alu_result = r_op_a & r_op_b;
            c_CMD_NAND: w_alu_result = ~(r_op_a & r_op_b);
            c_CMD_NOR:  w_alu_result = ~(r_op_a | r_op_b);
            c_CMD_OR:   w_alu_result = r_op_a | r_op_b;
            default:    w_alu_result = '0;
        endcase
    end

    // Response register: loaded at the end of EXEC, held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_carry  <= 1'b0;
            r_resp_zero   <= 1'b0;
            r_resp_ovf    <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_resp_valid  <= 1'b1;
            r_resp_id     <= r_op_id;
            r_resp_result <= w_alu_result;
            r_resp_carry  <= w_alu_carry;
            r_resp_zero   <= ~|w_alu_result;
            r_resp_ovf    <= w_alu_ovf;
        end else if (w_release) begin
            r_resp_valid  <= 1'b0;
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_id       = r_resp_id;
    assign resp_result   = r_resp_result;
    assign resp_carryout = r_resp_carry;
    assign resp_zero     = r_resp_zero;
    assign resp_overflow = r_resp_ovf;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter: reference model of the
//                round-robin FSM and ALU feeding a response scoreboard, plus
//                directed operand cases with constant expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*3-1:0]  req_cmd;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [31:0]           resp_result;
    logic                  resp_carryout;
    logic                  resp_zero;
    logic                  resp_overflow;

    typedef struct {
        int          id;
        logic [31:0] result;
        logic        carry;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_errors = 0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cmd       (req_cmd),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_carryout (resp_carryout),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU written from signed/unsigned arithmetic semantics
    function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        exp_t   e;
        longint sa, sb2, s;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        e.id = 0;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        case (cmd)
            c_CMD_ADD: begin
                e.result = a + b;
                e.carry  = ((64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF);
                s = sa + sb2;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            c_CMD_SUB, c_CMD_SLT: begin
                e.result = (cmd == c_CMD_SUB) ? (a - b) : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                e.carry  = (a >= b);
                s = sa - sb2;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            c_CMD_XOR:  e.result = a ^ b;
            c_CMD_AND:  e.result = a & b;
            c_CMD_NAND: e.result = ~(a & b);
            c_CMD_NOR:  e.result = ~(a | b);
            default:    e.result = a | b;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Reference FSM: predicts grants, pushes expected responses, checks outputs
    initial begin : monitor
        int                 m_state;
        int                 m_ptr;
        int                 g;
        logic [NUM_REQ-1:0] er;
        exp_t               e;
        m_state = 0;
        m_ptr   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ready_in_reset", 32'(req_ready), 32'd0);
                m_state = 0;
                m_ptr   = 0;
                sb.delete();
            end else begin
                case (m_state)
                    0: begin
                        g  = rr_pick(m_ptr, req_valid);
                        er = '0;
                        if (g >= 0) er[g] = 1'b1;
                        check("req_ready_idle", 32'(req_ready), 32'(er));
                        check("resp_valid_idle", 32'(resp_valid), 32'd0);
                        if (g >= 0) begin
                            e = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], req_cmd[3*g +: 3]);
                            e.id = g;
                            sb.push_back(e);
                            m_ptr   = (g + 1) % NUM_REQ;
                            m_state = 1;
                        end
                    end
                    1: begin
                        check("req_ready_exec", 32'(req_ready), 32'd0);
                        check("resp_valid_exec", 32'(resp_valid), 32'd0);
                        m_state = 2;
                    end
                    default: begin
                        check("req_ready_resp", 32'(req_ready), 32'd0);
                        check("resp_valid_resp", 32'(resp_valid), 32'd1);
                        if (sb.size() == 0) begin
                            check("sb_underflow", 32'd0, 32'd1);
                        end else begin
                            e = sb[0];
                            check("resp_id", 32'(resp_id), 32'(e.id));
                            check("resp_result", resp_result, e.result);
                            check("resp_carry", 32'(resp_carryout), 32'(e.carry));
                            check("resp_zero", 32'(resp_zero), 32'(e.zero));
                            check("resp_ovf", 32'(resp_overflow), 32'(e.ovf));
                        end
                        if (resp_ready) begin
                            if (sb.size() != 0) void'(sb.pop_front());
                            m_state = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Raise one request, wait (bounded) for its grant, then drop valid
    task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        int n;
        @(posedge clk);
        #1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cmd[3*i +: 3] = cmd;
        req_valid[i]      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 30);
        if (!req_ready[i]) check("grant_timeout", 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // Directed op with constant expectations and two-cycle latency check
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                          input logic [31:0] exp_res, input logic [2:0] exp_czo);
        do_req(i, a, b, cmd);
        @(negedge clk);
        check("lat_exec_low", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("lat_resp_high", 32'(resp_valid), 32'd1);
        check("dir_result", resp_result, exp_res);
        check("dir_id", 32'(resp_id), 32'(i));
        check("dir_flags", 32'({resp_carryout, resp_zero, resp_overflow}), 32'(exp_czo));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        num_errors++;
        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

    initial begin : stimulus
        logic [2:0] cmds [6];
        cmds = '{c_CMD_XOR, c_CMD_AND, c_CMD_NAND, c_CMD_NOR, c_CMD_OR, c_CMD_ADD};
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cmd    = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_flags", 32'({resp_carryout, resp_zero, resp_overflow}), 32'd0);

        // Single requester ADD, signed/unsigned SUB and SLT corners
        run_op(0, 32'd5, 32'd7, c_CMD_ADD, 32'd12, 3'b000);
        run_op(1, 32'h8000_0000, 32'd1, c_CMD_SUB, 32'h7FFF_FFFF, 3'b101);
        run_op(0, 32'd5, 32'd5, c_CMD_SUB, 32'd0, 3'b110);
        run_op(1, 32'hFFFF_FFFF, 32'd1, c_CMD_SLT, 32'd1, 3'b100);
        run_op(0, 32'd1, 32'hFFFF_FFFF, c_CMD_SLT, 32'd0, 3'b010);
        repeat (3) @(negedge clk);

        // Random operands across the logic ops, alternating requesters
        for (int t = 0; t < 6; t++) begin
            do_req(t % 2, $urandom, $urandom, cmds[t]);
        end
        repeat (4) @(negedge clk);

        // Both requesters continuously valid: grants must alternate
        @(posedge clk);
        #1;
        req_a     = {32'd100, 32'd200};
        req_b     = {32'd3, 32'd200};
        req_cmd   = {c_CMD_SUB, c_CMD_XOR};
        req_valid = 2'b11;
        repeat (13) @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(negedge clk);

        // Response back-pressure with req1 waiting; req1 only granted after accept
        resp_ready = 1'b0;
        do_req(0, 32'h1234_5678, 32'h0F0F_0F0F, c_CMD_AND);
        req_a[63:32]  = 32'd9;
        req_b[63:32]  = 32'd4;
        req_cmd[5:3]  = c_CMD_ADD;
        req_valid[1]  = 1'b1;
        repeat (6) @(posedge clk);
        #1 resp_ready = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready[1] && n < 10);
            check("bp_req1_grant", 32'(req_ready), 32'b10);
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while in EXEC drops the op and returns the pointer to 0
        do_req(0, 32'd77, 32'd1, c_CMD_ADD);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        req_a     = {32'd8, 32'd2};
        req_b     = {32'd1, 32'd3};
        req_cmd   = {c_CMD_OR, c_CMD_ADD};
        req_valid = 2'b11;
        @(negedge clk);
        check("post_rst_first_grant", 32'(req_ready), 32'b01);
        check("post_rst_no_resp", 32'(resp_valid), 32'd0);
        repeat (7) @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
